// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: issues one registered byte plus a one-cycle strobe
// per frame, paced on tx_busy. Optional drop accounting under UART_TX_FEED_OVERFLOW_EN.
module uart_tx_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
`ifdef UART_TX_FEED_OVERFLOW_EN
    input  logic                  overflow_clr,
    output logic                  overflow,
    output logic [7:0]            drop_cnt,
`endif
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid
);

    localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    push, pop;

    // Flags come from the registered pointers only, so a pop never unblocks a same-cycle write.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    assign push = wr_en && !full;
    assign pop  = (state_q == StIdle) && !empty && !tx_busy;

    assign wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (pop) state_d = StIssue;
            StIssue:    state_d = StWaitBusy;
            StWaitBusy: if (tx_busy) state_d = StWaitDone;
            StWaitDone: if (!tx_busy) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // tx_data holds between pops; the strobe is only ever high for the cycle after a pop.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        if (pop) begin
            tx_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            tx_valid_d = 1'b1;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;

`ifdef UART_TX_FEED_OVERFLOW_EN
    logic       overflow_q, overflow_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop;

    assign drop = wr_en && full;

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule
